mem_access_unit: RTL and testbench

//  Memory-stage load/store unit between the pipeline M stage and the data-memory bus.

---
 rtl/mem_access_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Memory-stage load/store unit. It takes the M-stage effective address and
//   store data and runs one req/addr_ok/data_ok transaction on the data bus.
//   Stores are aligned into byte lanes with matching strobes. Loads are
//   sign- or zero-extended. The unit holds the pipeline with stallM while a
//   transaction is outstanding. The completion cycle (doneM) drops the stall
//   so that the M->W register can capture rdataM.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   memenM, memopM           M-stage memory enable and op code
//                            (LB,LBU,LH,LHU,LW,SB,SH,SW)
//   addrM, wdataM, flushM    effective address, raw store data, cancel
//   rdataM, doneM, berrM     extended load result, completion, bus timeout
//   stallM, adelM, adesM     pipeline freeze, load/store misalignment
//   data_req .. data_wdata   registered bus request side
//   data_addr_ok, data_data_ok, data_rdata   bus handshake and read data
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic [2:0]  memopM,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    input  logic        flushM,
    output logic [31:0] rdataM,
    output logic        doneM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic        berrM,
    output logic        data_req,
    output logic        data_wr,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } stateT;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    stateT       state;
    stateT       nextState;
    logic        isLoad;
    logic        isStore;
    logic        misal;
    logic        go;
    logic        killNow;
    logic        killFlag;
    logic        timeoutFlag;
    logic [7:0]  waitCnt;
    logic [2:0]  opReg;
    logic [1:0]  offReg;

    // Byte enables for a store. Loads drive no strobes.
    function automatic logic [3:0] storeStrb(input logic [2:0] op, input logic [1:0] off);
        case (op)
            3'b101:  storeStrb = 4'b0001 << off;
            3'b110:  storeStrb = off[1] ? 4'b1100 : 4'b0011;
            3'b111:  storeStrb = 4'b1111;
            default: storeStrb = 4'b0000;
        endcase
    endfunction

    // Replicate the store data across the lanes so the strobes pick the right copy.
    function automatic logic [31:0] storeData(input logic [2:0] op, input logic [31:0] wd);
        case (op)
            3'b101:  storeData = {4{wd[7:0]}};
            3'b110:  storeData = {2{wd[15:0]}};
            3'b111:  storeData = wd;
            default: storeData = 32'd0;
        endcase
    endfunction

    // Select the addressed byte or halfword and extend it according to the op.
    function automatic logic [31:0] loadExtend(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] rd);
        logic [7:0]          b;
        logic [15:0]         h;
        logic signed [7:0]   sByte;
        logic signed [15:0]  sHalf;
        b     = rd[{off, 3'b000} +: 8];
        h     = rd[{off[1], 4'b0000} +: 16];
        sByte = signed'(b);
        sHalf = signed'(h);
        case (op)
            3'b000:  loadExtend = 32'(sByte);
            3'b001:  loadExtend = {24'd0, b};
            3'b010:  loadExtend = 32'(sHalf);
            3'b011:  loadExtend = {16'd0, h};
            default: loadExtend = rd;
        endcase
    endfunction

    // Op decode and alignment check on the live M-stage inputs.
    always_comb begin
        isLoad  = (memopM <= 3'b100);
        isStore = ~isLoad;
        case (memopM)
            3'b010, 3'b011, 3'b110: misal = addrM[0];
            3'b100, 3'b111:         misal = |addrM[1:0];
            default:                misal = 1'b0;
        endcase
        go = memenM & ~misal & ~flushM;
    end

    // A flush seen during WAIT also cancels the result, not only one seen at the handshake.
    assign killNow = killFlag | flushM;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (go) nextState = ST_REQ;
            end
            ST_REQ: begin
                if (data_addr_ok)  nextState = ST_WAIT;
                else if (flushM)   nextState = ST_IDLE;
            end
            ST_WAIT: begin
                if (data_data_ok || (waitCnt == WAIT_LIMIT))
                    nextState = killNow ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                nextState = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        doneM  = (state == ST_DONE);
        berrM  = (state == ST_DONE) & timeoutFlag;
        stallM = ((state == ST_IDLE) & go) | (state == ST_REQ) | (state == ST_WAIT);
        adelM  = memenM & isLoad & misal;
        adesM  = memenM & isStore & misal;
    end

    // Bus request registers, wait counter and the captured result
    always_ff @(posedge clk) begin
        if (rst) begin
            data_req    <= 1'b0;
            data_wr     <= 1'b0;
            data_addr   <= 32'd0;
            data_wstrb  <= 4'd0;
            data_wdata  <= 32'd0;
            rdataM      <= 32'd0;
            opReg       <= 3'd0;
            offReg      <= 2'd0;
            killFlag    <= 1'b0;
            timeoutFlag <= 1'b0;
            waitCnt     <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        data_req    <= 1'b1;
                        data_wr     <= isStore;
                        data_addr   <= {addrM[31:2], 2'b00};
                        data_wstrb  <= storeStrb(memopM, addrM[1:0]);
                        data_wdata  <= storeData(memopM, wdataM);
                        opReg       <= memopM;
                        offReg      <= addrM[1:0];
                        killFlag    <= 1'b0;
                        timeoutFlag <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        killFlag <= flushM;
                        // Counting from 1 makes WAIT_MAX the number of WAIT cycles spent.
                        waitCnt  <= 8'd1;
                    end else if (flushM) begin
                        data_req <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    waitCnt <= waitCnt + 8'd1;
                    if (flushM) killFlag <= 1'b1;
                    if (data_data_ok) begin
                        timeoutFlag <= 1'b0;
                        // Stores leave the previous load result untouched.
                        if (!killNow && (opReg <= 3'b100))
                            rdataM <= loadExtend(opReg, offReg, data_rdata);
                    end else if ((waitCnt == WAIT_LIMIT) && !killNow) begin
                        timeoutFlag <= 1'b1;
                        rdataM      <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int WAIT_MAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM;
    logic [2:0]  memopM;
    logic [31:0] addrM;
    logic [31:0] wdataM;
    logic        flushM;
    logic [31:0] rdataM;
    logic        doneM;
    logic        stallM;
    logic        adelM;
    logic        adesM;
    logic        berrM;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int vecCount = 0;
    int errCount = 0;
    logic [31:0] lastRdata = 32'd0;

    logic [31:0] expQ[$];
    logic [3:0]  strbQ[$];
    logic [31:0] addrQ[$];

    // Load table: op, address, bus word, extended result
    logic [2:0]  ldOp[7]   = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b010};
    logic [31:0] ldAddr[7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h100};
    logic [31:0] ldRd[7]   = '{32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233,
                               32'h89ABCDEF, 32'h80112233, 32'h80112233};
    logic [31:0] ldExp[7]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011,
                               32'h89ABCDEF, 32'h00000033, 32'h00002233};

    // Store table: op, address, raw data, strobes, lane data, word address
    logic [2:0]  stOp[5]   = '{3'b101, 3'b110, 3'b101, 3'b110, 3'b111};
    logic [31:0] stAddr[5] = '{32'h201, 32'h202, 32'h203, 32'h300, 32'h304};
    logic [31:0] stWd[5]   = '{32'h000000A5, 32'h00001234, 32'h000011C3, 32'hFFFFBEEF, 32'hDEADBEEF};
    logic [3:0]  stStrb[5] = '{4'b0010, 4'b1100, 4'b1000, 4'b0011, 4'b1111};
    logic [31:0] stData[5] = '{32'hA5A5A5A5, 32'h12341234, 32'hC3C3C3C3, 32'hBEEFBEEF, 32'hDEADBEEF};
    logic [31:0] stWord[5] = '{32'h200, 32'h200, 32'h200, 32'h300, 32'h304};

    always #5 clk = ~clk;

    mem_access_unit #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .memenM(memenM), .memopM(memopM), .addrM(addrM),
        .wdataM(wdataM), .flushM(flushM), .rdataM(rdataM), .doneM(doneM),
        .stallM(stallM), .adelM(adelM), .adesM(adesM), .berrM(berrM),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vecCount++;
        if ({data_req, data_wr, data_wstrb, doneM, berrM, stallM} !== 9'd0) begin
            errCount++;
            $display("FAIL reset_ctrl: got %b want 0", {data_req, data_wr, data_wstrb, doneM, berrM, stallM});
        end
        vecCount++;
        if ({data_addr, data_wdata, rdataM} !== 96'd0) begin
            errCount++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h want all 0", data_addr, data_wdata, rdataM);
        end
        rst = 1'b0;
    endtask

    task automatic test_lw_sequence();
        logic [31:0] exp;
        expQ.push_back(32'h89ABCDEF);
        @(posedge clk); #1;
        memenM = 1'b1; memopM = 3'b100; addrM = 32'h100; flushM = 1'b0;
        @(negedge clk);
        vecCount++;
        if ({stallM, data_req} !== 2'b10) begin
            errCount++; $display("FAIL lw_idle: stall,req got %b want 10", {stallM, data_req});
        end
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(negedge clk);
        vecCount++;
        if ({stallM, data_req, data_wr, data_wstrb} !== 7'b1100000 || data_addr !== 32'h100) begin
            errCount++;
            $display("FAIL lw_req: stall,req,wr,strb %b addr %h want 1100000 / 00000100",
                     {stallM, data_req, data_wr, data_wstrb}, data_addr);
        end
        @(posedge clk); #1;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h89ABCDEF;
        @(negedge clk);
        vecCount++;
        if ({stallM, data_req, doneM} !== 3'b100) begin
            errCount++; $display("FAIL lw_wait: stall,req,done got %b want 100", {stallM, data_req, doneM});
        end
        @(posedge clk); #1;
        data_data_ok = 1'b0; data_rdata = 32'd0;
        @(negedge clk);
        exp = expQ.pop_front();
        vecCount++;
        if ({doneM, stallM, berrM} !== 3'b100 || rdataM !== exp) begin
            errCount++;
            $display("FAIL lw_done: done,stall,berr %b rdata %h want 100 / %h", {doneM, stallM, berrM}, rdataM, exp);
        end
        lastRdata = exp;
        memenM = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vecCount++;
        if ({doneM, stallM} !== 2'b00 || rdataM !== lastRdata) begin
            errCount++;
            $display("FAIL lw_hold: done,stall %b rdata %h want 00 / %h", {doneM, stallM}, rdataM, lastRdata);
        end
    endtask

    task automatic test_loads();
        logic seen;
        logic hs;
        logic [31:0] exp;
        for (int i = 0; i < 7; i++) begin
            expQ.push_back(ldExp[i]);
            @(posedge clk); #1;
            memenM = 1'b1; memopM = ldOp[i]; addrM = ldAddr[i]; data_rdata = ldRd[i];
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (doneM) begin
                    exp = expQ.pop_front();
                    vecCount++;
                    if (rdataM !== exp || berrM !== 1'b0) begin
                        errCount++;
                        $display("FAIL load_%0d: rdata %h berr %b want %h / 0", i, rdataM, berrM, exp);
                    end
                    lastRdata = exp;
                    seen = 1'b1;
                    memenM = 1'b0;
                end
                hs = data_req & data_addr_ok;
                @(posedge clk); #1;
                data_data_ok = hs; data_addr_ok = data_req;
            end
            if (!seen) begin
                vecCount++; errCount++;
                $display("FAIL load_%0d_timeout: doneM got 0 want 1", i);
                void'(expQ.pop_front());
            end
            data_addr_ok = 1'b0; data_data_ok = 1'b0;
        end
    endtask

    task automatic test_flush_wait();
        logic sawDone = 1'b0;
        @(posedge clk); #1;
        memenM = 1'b1; memopM = 3'b100; addrM = 32'h104;
        @(posedge clk); #1;
        data_addr_ok = 1'b1; flushM = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vecCount++;
            if (stallM !== 1'b1) begin
                errCount++; $display("FAIL flush_wait_stall_%0d: stallM got %b want 1", c, stallM);
            end
            @(posedge clk); #1;
        end
        data_data_ok = 1'b1; data_rdata = 32'h12345678;
        @(posedge clk); #1;
        data_data_ok = 1'b0; memenM = 1'b0; flushM = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (doneM) sawDone = 1'b1;
            @(posedge clk); #1;
        end
        vecCount++;
        if (sawDone !== 1'b0 || stallM !== 1'b0 || rdataM !== lastRdata) begin
            errCount++;
            $display("FAIL flush_wait: done seen %b stall %b rdata %h want 0 / 0 / %h", sawDone, stallM, rdataM, lastRdata);
        end
    endtask

    task automatic test_stores();
        logic seen;
        logic reqSeen;
        logic hs;
        logic [31:0] eAddr;
        logic [31:0] eData;
        logic [3:0]  eStrb;
        for (int i = 0; i < 5; i++) begin
            strbQ.push_back(stStrb[i]); expQ.push_back(stData[i]); addrQ.push_back(stWord[i]);
            @(posedge clk); #1;
            memenM = 1'b1; memopM = stOp[i]; addrM = stAddr[i]; wdataM = stWd[i]; data_rdata = 32'd0;
            seen = 1'b0; reqSeen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (data_req && !reqSeen) begin
                    reqSeen = 1'b1;
                    eStrb = strbQ.pop_front(); eData = expQ.pop_front(); eAddr = addrQ.pop_front();
                    vecCount++;
                    if (data_wr !== 1'b1 || data_wstrb !== eStrb || data_wdata !== eData || data_addr !== eAddr) begin
                        errCount++;
                        $display("FAIL store_%0d: wr %b strb %b wdata %h addr %h want 1 %b %h %h",
                                 i, data_wr, data_wstrb, data_wdata, data_addr, eStrb, eData, eAddr);
                    end
                end
                if (doneM) begin
                    vecCount++;
                    if (berrM !== 1'b0) begin
                        errCount++; $display("FAIL store_%0d_berr: got %b want 0", i, berrM);
                    end
                    seen = 1'b1;
                    memenM = 1'b0;
                end
                hs = data_req & data_addr_ok;
                @(posedge clk); #1;
                data_data_ok = hs; data_addr_ok = data_req;
            end
            if (!seen || !reqSeen) begin
                vecCount++; errCount++;
                $display("FAIL store_%0d_timeout: req seen %b done seen %b want 1 1", i, reqSeen, seen);
            end
            data_addr_ok = 1'b0; data_data_ok = 1'b0;
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  mOp[4]   = '{3'b100, 3'b110, 3'b010, 3'b111};
        logic [31:0] mAddr[4] = '{32'h102, 32'h101, 32'h103, 32'h302};
        logic [1:0]  mExp[4]  = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic anyReq;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            memenM = 1'b1; memopM = mOp[i]; addrM = mAddr[i];
            #1;
            vecCount++;
            if ({adelM, adesM} !== mExp[i] || stallM !== 1'b0) begin
                errCount++;
                $display("FAIL misal_%0d: adel,ades %b stall %b want %b / 0", i, {adelM, adesM}, stallM, mExp[i]);
            end
            anyReq = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (data_req) anyReq = 1'b1;
            end
            vecCount++;
            if (anyReq !== 1'b0) begin
                errCount++; $display("FAIL misal_%0d_req: data_req seen %b want 0", i, anyReq);
            end
            memenM = 1'b0;
        end
    endtask

    task automatic test_flush_req();
        logic sawDone = 1'b0;
        @(posedge clk); #1;
        memenM = 1'b1; memopM = 3'b100; addrM = 32'h100; data_addr_ok = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vecCount++;
            if ({data_req, stallM} !== 2'b11) begin
                errCount++; $display("FAIL flush_req_hold_%0d: req,stall got %b want 11", c, {data_req, stallM});
            end
            @(posedge clk); #1;
        end
        flushM = 1'b1;
        @(posedge clk); #1;
        memenM = 1'b0; flushM = 1'b0;
        @(negedge clk);
        vecCount++;
        if ({data_req, stallM} !== 2'b00) begin
            errCount++; $display("FAIL flush_req: req,stall got %b want 00", {data_req, stallM});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (doneM) sawDone = 1'b1;
        end
        vecCount++;
        if (sawDone !== 1'b0) begin
            errCount++; $display("FAIL flush_req_done: done seen %b want 0", sawDone);
        end
    endtask

    task automatic test_timeout();
        int waitCycles = 0;
        logic seen = 1'b0;
        logic [31:0] exp;
        expQ.push_back(32'd0);
        @(posedge clk); #1;
        memenM = 1'b1; memopM = 3'b100; addrM = 32'h100;
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(negedge clk);
            if (doneM) begin
                seen = 1'b1;
                exp = expQ.pop_front();
                vecCount++;
                if (berrM !== 1'b1 || rdataM !== exp) begin
                    errCount++; $display("FAIL timeout_done: berr %b rdata %h want 1 / %h", berrM, rdataM, exp);
                end
                memenM = 1'b0;
            end else if (stallM) begin
                waitCycles++;
            end
            @(posedge clk); #1;
        end
        vecCount++;
        if (!seen || waitCycles != WAIT_MAX) begin
            errCount++; $display("FAIL timeout_len: done %b wait cycles %0d want 1 / %0d", seen, waitCycles, WAIT_MAX);
        end
        @(negedge clk);
        vecCount++;
        if ({berrM, doneM} !== 2'b00) begin
            errCount++; $display("FAIL timeout_clear: berr,done got %b want 00", {berrM, doneM});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals[3] = '{32'hA1A2A3A4, 32'h0BADF00D, 32'h7FFF0001};
        int done = 0;
        int lastDoneCyc = -1;
        logic hs;
        logic [31:0] exp;
        for (int k = 0; k < 3; k++) expQ.push_back(vals[k]);
        @(posedge clk); #1;
        memenM = 1'b1; memopM = 3'b100; addrM = 32'h400; data_rdata = vals[0];
        for (int c = 0; c < 40 && done < 3; c++) begin
            @(negedge clk);
            if (doneM) begin
                exp = expQ.pop_front();
                vecCount++;
                if (rdataM !== exp) begin
                    errCount++; $display("FAIL b2b_%0d: rdata %h want %h", done, rdataM, exp);
                end
                done++;
                lastDoneCyc = c;
                if (done < 3) begin
                    addrM = 32'h400 + 32'(4 * done); data_rdata = vals[done];
                end else begin
                    memenM = 1'b0;
                end
            end
            hs = data_req & data_addr_ok;
            @(posedge clk); #1;
            data_data_ok = hs; data_addr_ok = data_req;
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        vecCount++;
        if (done != 3 || lastDoneCyc != 11) begin
            errCount++; $display("FAIL b2b_timing: done %0d last done cycle %0d want 3 / 11", done, lastDoneCyc);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        memenM = 1'b1; memopM = 3'b100; addrM = 32'h500;
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        vecCount++;
        if (stallM !== 1'b1) begin
            errCount++; $display("FAIL rstmid_wait: stallM got %b want 1", stallM);
        end
        rst = 1'b1; memenM = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vecCount++;
        if ({data_req, data_wr, data_wstrb, doneM, berrM, stallM} !== 9'd0 ||
            {data_addr, data_wdata, rdataM} !== 96'd0) begin
            errCount++;
            $display("FAIL rstmid: ctrl %b addr %h wdata %h rdata %h want all 0",
                     {data_req, data_wr, data_wstrb, doneM, berrM, stallM}, data_addr, data_wdata, rdataM);
        end
        rst = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        data_data_ok = 1'b0;
        @(negedge clk);
        vecCount++;
        if ({doneM, stallM} !== 2'b00 || rdataM !== 32'd0) begin
            errCount++; $display("FAIL rstmid_stray: done,stall %b rdata %h want 00 / 0", {doneM, stallM}, rdataM);
        end
    endtask

    initial begin
        rst = 1'b1; memenM = 1'b0; memopM = 3'b000; addrM = 32'd0; wdataM = 32'd0;
        flushM = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        test_reset();
        test_lw_sequence();
        test_loads();
        test_flush_wait();
        test_stores();
        test_misaligned();
        test_flush_req();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
